// File: rtl/scope_capture_scheduler_if.sv
// Signal bundle between the scope capture scheduler and its sample source,
// raster timing and the dual-bank sample RAM.
interface scope_capture_scheduler_if;
  logic [15:0] H_count_Value;
  logic [15:0] V_count_Value;
  logic        adc_valid;
  logic [7:0]  adc_data;
  logic [7:0]  trig_level;
  logic        trig_rising;
  logic        single_shot;
  logic        arm;
  logic        ram_en;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        disp_active;
  logic        frame_valid;
  logic        capturing;
  logic        overflow;

  modport master (
    output H_count_Value, V_count_Value, adc_valid, adc_data,
           trig_level, trig_rising, single_shot, arm,
    input  ram_en, ram_we, ram_addr, ram_wdata,
           disp_active, frame_valid, capturing, overflow
  );

  modport slave (
    input  H_count_Value, V_count_Value, adc_valid, adc_data,
           trig_level, trig_rising, single_shot, arm,
    output ram_en, ram_we, ram_addr, ram_wdata,
           disp_active, frame_valid, capturing, overflow
  );
endinterface

// File: rtl/scope_capture_scheduler.sv
// Triggered ADC capture into the back bank of a ping-pong sample RAM, sharing the
// RAM port with the VGA display reader, which always wins arbitration.
module scope_capture_scheduler #(
  parameter int N_SAMPLES   = 640,
  parameter int FIFO_DEPTH  = 16,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514,
  parameter int H_MAX       = 799,
  parameter int V_MAX       = 524
) (
  input  logic                      clk_25MHz,
  input  logic                      rst_n,
  scope_capture_scheduler_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] H_S  = 16'(H_ACT_START);
  localparam logic [15:0] H_E  = 16'(H_ACT_END);
  localparam logic [15:0] V_S  = 16'(V_ACT_START);
  localparam logic [15:0] V_E  = 16'(V_ACT_END);
  localparam logic [15:0] H_M  = 16'(H_MAX);
  localparam logic [15:0] V_M  = 16'(V_MAX);
  localparam logic [9:0]  LAST = 10'(N_SAMPLES - 1);
  localparam logic [PW-1:0] PTR_TOP = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  typedef struct packed {
    logic [10:0] tag;
    logic [7:0]  data;
  } fifo_ent_t;

  state_t        state;
  logic          front_bank, back_bank;
  logic          frame_valid_q, overflow_q, prev_valid;
  logic [9:0]    wr_index;
  logic [7:0]    prev_sample;

  fifo_ent_t     mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          disp_active, frame_end;
  logic          fifo_empty, fifo_full;
  logic          trig_hit, push, push_ok, pop, last_idx;
  logic [9:0]    push_idx, h_off;
  fifo_ent_t     push_ent, head;

  assign disp_active = (bus.H_count_Value >= H_S) && (bus.H_count_Value <= H_E) &&
                       (bus.V_count_Value >= V_S) && (bus.V_count_Value <= V_E);
  assign frame_end   = (bus.H_count_Value == H_M) && (bus.V_count_Value == V_M);
  assign h_off       = bus.H_count_Value[9:0] - H_S[9:0];
  assign back_bank   = ~front_bank;

  // The very first sample after arming only seeds prev_sample.
  always_comb begin
    if (bus.trig_rising)
      trig_hit = prev_valid && (prev_sample < bus.trig_level) && (bus.adc_data >= bus.trig_level);
    else
      trig_hit = prev_valid && (prev_sample > bus.trig_level) && (bus.adc_data <= bus.trig_level);
  end

  assign push     = bus.adc_valid && (((state == ARMED) && trig_hit) || (state == CAPTURE));
  assign push_idx = (state == ARMED) ? 10'd0 : wr_index;
  assign push_ent = '{tag: {back_bank, push_idx}, data: bus.adc_data};
  assign last_idx = (push_idx == LAST);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign push_ok    = push && !fifo_full;
  assign pop        = !disp_active && !fifo_empty;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk_25MHz) begin
    if (push_ok) mem[wr_ptr] <= push_ent;
  end

  // A push into a full FIFO is dropped even if a pop frees a slot in the same cycle.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_TOP) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PTR_TOP) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // wr_index advances on dropped samples too, so a drop leaves a hole rather
  // than shifting later samples out of time alignment.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      front_bank    <= 1'b0;
      wr_index      <= '0;
      prev_sample   <= '0;
      prev_valid    <= 1'b0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (push && fifo_full) overflow_q <= 1'b1;
      if (bus.adc_valid && ((state == ARMED) || (state == CAPTURE))) begin
        prev_sample <= bus.adc_data;
        prev_valid  <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.arm || (frame_end && !bus.single_shot)) begin
            state      <= ARMED;
            prev_valid <= 1'b0;
          end
        end
        ARMED: begin
          if (push) begin
            wr_index <= last_idx ? 10'd0 : 10'd1;
            state    <= last_idx ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.adc_valid) begin
            if (last_idx) begin
              wr_index <= '0;
              state    <= DONE;
            end else begin
              wr_index <= wr_index + 10'd1;
            end
          end
        end
        DONE: begin
          if (frame_end && fifo_empty) begin
            front_bank    <= ~front_bank;
            frame_valid_q <= 1'b1;
            prev_valid    <= 1'b0;
            state         <= bus.single_shot ? IDLE : ARMED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port is held quiet during reset even when the raster is in the active area.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (rst_n) begin
      if (disp_active) begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = {front_bank, h_off};
      end else if (!fifo_empty) begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = head.tag;
        bus.ram_wdata = head.data;
      end
    end
  end

  assign bus.disp_active = disp_active;
  assign bus.frame_valid = frame_valid_q;
  assign bus.capturing   = (state == CAPTURE);
  assign bus.overflow    = overflow_q;

endmodule
